ps2_rx: RTL and testbench

//  Receiver front end of the PS/2 keyboard peripheral (PS2_ADDR_HIGH = 8'h03 region).
//  - Deserialises the device-driven ps2_clk/ps2_dat frames into 8-bit scan codes.
//  - Checks framing and parity, and holds each code until the bus-side register logic acknowledges it.
//  - Sits directly after the board pins and feeds the PS/2 peripheral's register file.

---
 rtl/ps2_rx_pkg.sv | 22 ++
 rtl/ps2_rx_sync_filter.sv | 60 ++++++
 rtl/ps2_rx.sv | 159 +++++++++++++++
 tb/tb_ps2_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_pkg.sv
// ps2_rx_pkg: shared types and constants for the PS/2 receive path.
//   ps2_state_t     receiver FSM states
//   PS2_FRAME_BITS  bits per PS/2 frame (start, 8 data, parity, stop)
//   PS2_DATA_BITS   payload bits per frame
//   ps2_parity_ok   odd-parity check over data plus parity bit
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    PS2_IDLE,
    PS2_DATA,
    PS2_PARITY,
    PS2_STOP
  } ps2_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_sync_filter.sv
// ps2_sync_filter: 2-FF synchroniser, FILTER_LEN-sample glitch filter and
// falling-edge pulse for an asynchronous, idle-high line.
//   clk_i   in   system clock
//   rst_i   in   synchronous reset, active-high
//   in_i    in   asynchronous input
//   filt_o  out  filtered level (1 after reset)
//   fall_o  out  1-cycle pulse on a filtered 1->0 transition
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive synced samples that disagree with the filtered level;
  // any agreeing sample restarts the count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    fall_d = 1'b0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 receiver front end. Deserialises device frames into scan
// codes, checks framing/parity, holds codes until acknowledged.
//   clk_i            in   system clock
//   rst_i            in   synchronous reset, active-high
//   ps2_clk_i        in   asynchronous PS/2 clock
//   ps2_dat_i        in   asynchronous PS/2 data
//   keycode_o        out  last received scan code
//   keycode_valid_o  out  keycode_o not yet acknowledged
//   keycode_ack_i    in   1-cycle consumer acknowledge
//   overflow_o       out  code overwritten before ack (sticky until ack)
//   frame_err_o      out  1-cycle pulse on bad frame or timeout
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 100
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] keycode_o,
  output logic       keycode_valid_o,
  input  logic       keycode_ack_i,
  output logic       overflow_o,
  output logic       frame_err_o
);

  localparam int TIMEOUT_CYCLES =
    int'((64'(TIMEOUT_US) * 64'(CLK_FREQ_HZ)) / 64'd1_000_000);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic ps2_clk_filt;
  logic fall;
  logic dat_sync1_q, dat_sync2_q;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .in_i   (ps2_clk_i),
    .filt_o (ps2_clk_filt),
    .fall_o (fall)
  );

  ps2_state_t    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          deliver;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    err_d    = 1'b0;
    deliver  = 1'b0;

    // Inter-edge watchdog: idle clears it, every fall restarts it, saturates.
    if (state_q == PS2_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    unique case (state_q)
      PS2_IDLE: begin
        if (fall && !dat_sync2_q) begin
          state_d  = PS2_DATA;
          bitcnt_d = '0;
        end
      end
      PS2_DATA: begin
        if (fall) begin
          shift_d  = {dat_sync2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PS2_PARITY;
        end
      end
      PS2_PARITY: begin
        if (fall) begin
          par_d   = dat_sync2_q;
          state_d = PS2_STOP;
        end
      end
      PS2_STOP: begin
        if (fall) begin
          if (dat_sync2_q && ps2_parity_ok(shift_q, par_q)) deliver = 1'b1;
          else                                               err_d   = 1'b1;
          state_d = PS2_IDLE;
        end
      end
      default: state_d = PS2_IDLE;
    endcase

    if (state_q != PS2_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      state_d = PS2_IDLE;
      err_d   = 1'b1;
    end
  end

  // Handshake: ack clears, a delivery in the same cycle overrides it.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (keycode_ack_i && valid_q) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
    if (deliver) begin
      code_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !keycode_ack_i) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_sync1_q <= 1'b1;
      dat_sync2_q <= 1'b1;
      state_q     <= PS2_IDLE;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dat_sync1_q <= ps2_dat_i;
      dat_sync2_q <= dat_sync1_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign keycode_o       = code_q;
  assign keycode_valid_o = valid_q;
  assign overflow_o      = ovf_q;
  assign frame_err_o     = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] keycode;
  logic       valid, ovf, ferr;

  int pass_cnt = 0;
  int total_cnt = 0;
  int err_cnt = 0;

  // Reference state: what a consumer of the peripheral should observe.
  logic [7:0] exp_code = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ovf = 1'b0;

  ps2_rx #(.CLK_FREQ_HZ(10_000_000), .FILTER_LEN(8), .TIMEOUT_US(100)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ps2_clk_i       (ps2_clk),
    .ps2_dat_i       (ps2_dat),
    .keycode_o       (keycode),
    .keycode_valid_o (valid),
    .keycode_ack_i   (ack),
    .overflow_o      (ovf),
    .frame_err_o     (ferr)
  );

  always #50 clk = ~clk;

  always @(posedge clk) if (ferr === 1'b1) err_cnt++;

  initial begin
    #9_500_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [10:0] make_frame(input logic [7:0] code, input logic bad_par);
    logic p;
    p = ~(^code);
    if (bad_par) p = ~p;
    return {1'b1, p, code, 1'b0};
  endfunction

  // Drives the first n bits of a frame; returns right after the last fall
  // (ps2_clk left low, at posedge+1).
  task automatic ps2_frame(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 ps2_dat = bits[i];
      repeat (149) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (i != n - 1) begin
        repeat (150) @(posedge clk);
        #1 ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic ps2_finish();
    repeat (150) @(posedge clk);
    #1 ps2_clk = 1'b1; ps2_dat = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    if (exp_valid) begin exp_valid = 1'b0; exp_ovf = 1'b0; end
  endtask

  // Full frame; optionally ack in the cycle the stop-bit delivery lands.
  task automatic send_full(input logic [7:0] code, input logic bad_par, input logic ack_in_dlv);
    ps2_frame(make_frame(code, bad_par), 11);
    repeat (10) @(posedge clk);
    if (ack_in_dlv) begin
      #1 ack = 1'b1;
      @(posedge clk); #1 ack = 1'b0;
    end else begin
      @(posedge clk);
    end
    if (!bad_par) begin
      exp_ovf   = ack_in_dlv ? 1'b0 : (exp_valid | exp_ovf);
      exp_valid = 1'b1;
      exp_code  = code;
    end
    ps2_finish();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_code = 8'h00; exp_valid = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic check_outputs(input string name);
    total_cnt++;
    if (keycode !== exp_code || valid !== exp_valid || ovf !== exp_ovf)
      $display("FAIL %s: got code=%h valid=%b ovf=%b want code=%h valid=%b ovf=%b",
               name, keycode, valid, ovf, exp_code, exp_valid, exp_ovf);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total_cnt++;
    if ({keycode, valid, ovf, ferr} !== 11'h0)
      $display("FAIL reset_outputs: got code=%h valid=%b ovf=%b err=%b want all 0", keycode, valid, ovf, ferr);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int e0;
    e0 = err_cnt;
    ps2_frame(make_frame(8'h1C, 1'b0), 11);
    repeat (10) @(posedge clk);
    #1;
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL latency_early: got valid=%b want 0 at 10 cycles", valid);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (valid !== 1'b1 || keycode !== 8'h1C)
      $display("FAIL latency_exact: got valid=%b code=%h want 1 1c at 11 cycles", valid, keycode);
    else pass_cnt++;
    exp_code = 8'h1C; exp_valid = 1'b1;
    ps2_finish();
    total_cnt++;
    if (err_cnt !== e0) $display("FAIL basic_no_err: got %0d errors want %0d", err_cnt, e0);
    else pass_cnt++;
    pulse_ack();
    #1;
    check_outputs("basic_ack");
  endtask

  task automatic test_parity_err();
    int e0;
    do_reset();
    e0 = err_cnt;
    send_full(8'h1C, 1'b1, 1'b0);
    total_cnt++;
    if (err_cnt !== e0 + 1) $display("FAIL parity_err_pulse: got %0d pulses want 1", err_cnt - e0);
    else pass_cnt++;
    check_outputs("parity_no_deliver");
  endtask

  task automatic test_timeout();
    int e0, hit;
    e0 = err_cnt; hit = -1;
    ps2_frame(make_frame(8'hA5, 1'b0), 5);
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); #1;
      if (i == 150) ps2_clk = 1'b1;
      if (ferr === 1'b1 && hit < 0) hit = i;
    end
    total_cnt++;
    if (hit < 1005 || hit > 1020)
      $display("FAIL timeout_time: got pulse at cycle %0d want 1005..1020", hit);
    else pass_cnt++;
    total_cnt++;
    if (err_cnt !== e0 + 1) $display("FAIL timeout_pulses: got %0d want 1", err_cnt - e0);
    else pass_cnt++;
    ps2_dat = 1'b1;
    e0 = err_cnt;
    send_full(8'hF0, 1'b0, 1'b0);
    check_outputs("after_timeout_rx");
    total_cnt++;
    if (err_cnt !== e0) $display("FAIL after_timeout_err: got %0d pulses want 0", err_cnt - e0);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    pulse_ack();
    send_full(8'hF0, 1'b0, 1'b0);
    check_outputs("ovf_first");
    send_full(8'h1C, 1'b0, 1'b0);
    check_outputs("ovf_set");
    pulse_ack();
    #1;
    check_outputs("ovf_ack_clear");
    send_full(8'hF0, 1'b0, 1'b0);
    send_full(8'h1C, 1'b0, 1'b0);
    check_outputs("ovf_set2");
    send_full(8'h29, 1'b0, 1'b1);
    check_outputs("ack_in_deliver");
  endtask

  task automatic test_glitch_and_reset();
    int e0;
    pulse_ack();
    e0 = err_cnt;
    @(posedge clk); #1 ps2_dat = 1'b0; ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    #1 ps2_dat = 1'b1;
    repeat (1100) @(posedge clk);
    total_cnt++;
    if (err_cnt !== e0) $display("FAIL glitch_err: got %0d pulses want 0", err_cnt - e0);
    else pass_cnt++;
    check_outputs("glitch_no_change");
    send_full(8'h5A, 1'b0, 1'b0);
    check_outputs("glitch_then_rx");
    ps2_frame(make_frame(8'h33, 1'b0), 5);
    ps2_finish();
    do_reset();
    #1;
    total_cnt++;
    if ({keycode, valid, ovf, ferr} !== 11'h0)
      $display("FAIL midframe_reset: got code=%h valid=%b ovf=%b err=%b want all 0", keycode, valid, ovf, ferr);
    else pass_cnt++;
    e0 = err_cnt;
    send_full(8'h1C, 1'b0, 1'b0);
    check_outputs("after_reset_rx");
    total_cnt++;
    if (err_cnt !== e0) $display("FAIL after_reset_err: got %0d pulses want 0", err_cnt - e0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int e0;
    logic [7:0] c;
    e0 = err_cnt;
    for (int k = 0; k < 5; k++) begin
      if ($urandom_range(0, 1) == 1) pulse_ack();
      c = 8'($urandom);
      send_full(c, 1'b0, 1'b0);
      check_outputs($sformatf("random_%0d", k));
    end
    total_cnt++;
    if (err_cnt !== e0) $display("FAIL random_err: got %0d pulses want 0", err_cnt - e0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_timeout();
    test_overflow();
    test_glitch_and_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
